// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// FSM encodings and field widths are kept here as macros and localparams so
// the fetch stage and its FIFO agree on one layout.
// Optional feature macro used by the top: FETCH_QUEUE_BYPASS_EN.
`ifndef FETCH_QUEUE_DEFINES_VH
`define FETCH_QUEUE_DEFINES_VH
`define FQ_REQ        2'd0
`define FQ_WAIT       2'd1
`define FQ_DROP       2'd2
`define FETCH_BLOCK_W 128
`define FETCH_PC_W    28
`endif

package fetch_queue_pkg;

    localparam int FETCH_BLOCK_W = `FETCH_BLOCK_W;
    localparam int FETCH_PC_W    = `FETCH_PC_W;
    localparam int FETCH_MASK_W  = 4;

    typedef enum logic [1:0] {
        FQ_S_REQ  = `FQ_REQ,
        FQ_S_WAIT = `FQ_WAIT,
        FQ_S_DROP = `FQ_DROP
    } fq_state_e;

    typedef struct packed {
        logic [FETCH_BLOCK_W-1:0] block;
        logic [FETCH_MASK_W-1:0]  mask;
        logic [FETCH_PC_W-1:0]    pc;
    } fetch_entry_t;

    // Slots before the entry word of a block are invalid; slot 0 is bit 3.
    function automatic logic [FETCH_MASK_W-1:0] entry_mask(input logic [1:0] slot);
        return 4'b1111 >> slot;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched blocks (instruction data, slot mask, block PC).
// A flush empties the buffer on the same edge and voids any push/pop issued
// in that cycle. The head entry is always presented on 'head'.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage write; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping, with flush taking priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage feeding the 4-wide decoder.
// Walks 16-byte blocks from RESET_PC, keeps one memory request in flight,
// queues returned blocks with their slot mask and block PC, and restarts at
// the back-end redirect PC, throwing away anything fetched on the old path.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN lets a response arriving into
// an empty queue appear on the outputs in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic                       imem_rvalid,
    input  logic [FETCH_BLOCK_W-1:0]   imem_rdata,
    input  logic                       next_ready,
    output logic                       out_valid,
    output logic [FETCH_BLOCK_W-1:0]   inst_4W_out,
    output logic [FETCH_MASK_W-1:0]    inst_4W_valid_out,
    output logic [FETCH_PC_W-1:0]      inst_4W_pc_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e                state;
    logic [29:0]              fetch_pc;
    logic                     first;
    logic [FETCH_PC_W-1:0]    req_pc;
    logic [FETCH_MASK_W-1:0]  req_mask;

    logic [CW-1:0]            count;
    logic [CW:0]              occupancy;
    logic                     space;
    logic [FETCH_MASK_W-1:0]  fetch_mask;
    logic                     accept;
    logic                     rsp_live;
    logic                     bypass_hit;
    logic                     push;
    logic                     pop;
    fetch_entry_t             push_data;
    fetch_entry_t             head;
    logic                     unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // A request in flight reserves a queue slot so the queue never overflows.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, (state == FQ_S_WAIT)};
    assign space      = int'(occupancy) < DEPTH;
    assign fetch_mask = first ? entry_mask(fetch_pc[1:0]) : 4'b1111;
    assign imem_req   = !rst && (state == FQ_S_REQ) && space && !redirect_valid;
    assign imem_addr  = {fetch_pc[29:2], 4'b0000};
    assign accept     = imem_req && imem_ack;
    assign rsp_live   = (state == FQ_S_WAIT) && imem_rvalid && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = rsp_live && (count == '0);
    assign push       = rsp_live && !(bypass_hit && next_ready);
`else
    assign bypass_hit = 1'b0;
    assign push       = rsp_live;
`endif

    assign pop       = (count != '0) && next_ready;
    assign out_valid = (count != '0) || bypass_hit;
    assign push_data = '{block: imem_rdata, mask: req_mask, pc: req_pc};

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    // Present the bypassed response or the queue head; zeros when idle.
    always_comb begin
        inst_4W_out       = '0;
        inst_4W_valid_out = '0;
        inst_4W_pc_out    = '0;
        if (bypass_hit) begin
            inst_4W_out       = imem_rdata;
            inst_4W_valid_out = req_mask;
            inst_4W_pc_out    = req_pc;
        end else if (count != '0) begin
            inst_4W_out       = head.block;
            inst_4W_valid_out = head.mask;
            inst_4W_pc_out    = head.pc;
        end
    end

    // Fetch sequencing: issue, wait for the response, or drop a stale one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FQ_S_REQ;
            fetch_pc <= RESET_PC[31:2];
            first    <= 1'b1;
            req_pc   <= '0;
            req_mask <= '0;
        end else begin
            case (state)
                FQ_S_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc[31:2];
                        first    <= 1'b1;
                    end else if (accept) begin
                        req_pc   <= fetch_pc[29:2];
                        req_mask <= fetch_mask;
                        fetch_pc <= {fetch_pc[29:2] + 28'd1, 2'b00};
                        first    <= 1'b0;
                        state    <= FQ_S_WAIT;
                    end
                end
                FQ_S_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc[31:2];
                        first    <= 1'b1;
                        state    <= imem_rvalid ? FQ_S_REQ : FQ_S_DROP;
                    end else if (imem_rvalid) begin
                        state    <= FQ_S_REQ;
                    end
                end
                FQ_S_DROP: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc[31:2];
                        first    <= 1'b1;
                    end
                    if (imem_rvalid) begin
                        state    <= FQ_S_REQ;
                    end
                end
                default: begin
                    state <= FQ_S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a transaction-level model tracks the
// fetch PC, the single in-flight request and the queue of expected blocks,
// while a randomized memory answers each accepted request after 1..N cycles.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic         clk;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic         imem_rvalid;
    logic [127:0] imem_rdata;
    logic         next_ready;
    logic         out_valid;
    logic [127:0] inst_4W_out;
    logic [3:0]   inst_4W_valid_out;
    logic [27:0]  inst_4W_pc_out;

    fetch_queue #(
        .RESET_PC          (RESET_PC),
        .DEPTH             (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .next_ready        (next_ready),
        .out_valid         (out_valid),
        .inst_4W_out       (inst_4W_out),
        .inst_4W_valid_out (inst_4W_valid_out),
        .inst_4W_pc_out    (inst_4W_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic [27:0]  pc;
    } blk_t;

    blk_t         model_q[$];
    logic [31:0]  model_pc;
    bit           model_first;
    bit           pending;
    bit           dropped;
    int           delay;
    logic [27:0]  pend_pc;
    logic [3:0]   pend_mask;
    int           cur_max_delay;

    logic [31:0]  accepted_addr[$];
    logic [31:0]  out_log[$];

    int           force_mode;
    logic [31:0]  force_target;

    int           vectors;
    int           miscompares;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Slots from the word addressed by pc up to slot 3 are valid on a first block.
    function automatic logic [3:0] slot_mask(input logic [31:0] pc, input bit is_first);
        logic [3:0] m;
        int start;
        start = is_first ? int'(pc[3:2]) : 0;
        for (int i = 0; i < 4; i++) begin
            m[3-i] = (i >= start);
        end
        return m;
    endfunction

    // Check the DUT for this cycle against the model, then advance the model.
    task automatic checkCycle();
        bit   exp_req;
        bit   byp;
        bit   exp_valid;
        blk_t exp_blk;
        exp_req = !pending && (model_q.size() < DEPTH) && !redirect_valid;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (model_q.size() == 0) && imem_rvalid && pending && !dropped && !redirect_valid;
`endif
        exp_valid = (model_q.size() != 0) || byp;

        checkOutput("imem_req", imem_req, exp_req);
        if (exp_req) begin
            checkOutput("imem_addr", imem_addr, {model_pc[31:4], 4'h0});
        end
        checkOutput("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            if (byp) begin
                exp_blk = '{data: imem_rdata, mask: pend_mask, pc: pend_pc};
            end else begin
                exp_blk = model_q[0];
            end
            checkOutput("inst_4W_out", inst_4W_out, exp_blk.data);
            checkOutput("inst_4W_valid_out", inst_4W_valid_out, exp_blk.mask);
            checkOutput("inst_4W_pc_out", inst_4W_pc_out, exp_blk.pc);
        end

        if (redirect_valid) begin
            model_q.delete();
            accepted_addr.delete();
            out_log.delete();
            model_pc    = {redirect_pc[31:2], 2'b00};
            model_first = 1'b1;
            if (pending) begin
                if (imem_rvalid) begin
                    pending = 1'b0;
                    dropped = 1'b0;
                end else begin
                    dropped = 1'b1;
                end
            end
        end else begin
            if (exp_valid && next_ready) begin
                out_log.push_back({inst_4W_valid_out, inst_4W_pc_out});
            end
            if (model_q.size() != 0 && next_ready) begin
                void'(model_q.pop_front());
            end
            if (imem_rvalid && pending) begin
                if (!dropped && !(byp && next_ready)) begin
                    model_q.push_back('{data: imem_rdata, mask: pend_mask, pc: pend_pc});
                end
                pending = 1'b0;
                dropped = 1'b0;
            end
            if (exp_req && imem_ack) begin
                pending   = 1'b1;
                dropped   = 1'b0;
                delay     = $urandom_range(cur_max_delay, 1);
                pend_pc   = model_pc[31:4];
                pend_mask = slot_mask(model_pc, model_first);
                accepted_addr.push_back({model_pc[31:4], 4'h0});
                model_pc    = {model_pc[31:4] + 28'd1, 4'h0};
                model_first = 1'b0;
            end
        end
    endtask

    // Drive one batch of cycles with the given input probabilities.
    task automatic applyStimulus(input int cycles, input int ack_pct, input int ready_pct,
                                 input int redir_pct, input int max_delay);
        cur_max_delay = max_delay;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pending) begin
                delay--;
                if (delay <= 0) imem_rvalid = 1'b1;
            end
            imem_rdata = dropped ? {4{32'hDEAD_BEEF}}
                                 : {$urandom, $urandom, $urandom, $urandom};
            imem_ack   = ($urandom_range(99) < ack_pct);
            next_ready = ($urandom_range(99) < ready_pct);
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (force_mode == 1 && !pending) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_target;
                force_mode     = 0;
            end else if (force_mode == 2 && pending && !dropped && !imem_rvalid) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_target;
                force_mode     = 0;
            end else if (force_mode == 0 && $urandom_range(99) < redir_pct) begin
                redirect_valid = 1'b1;
                if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF4;
            end
            @(negedge clk);
            checkCycle();
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        force_mode     = 0;
        force_target   = '0;
        model_pc       = RESET_PC;
        model_first    = 1'b1;
        pending        = 1'b0;
        dropped        = 1'b0;
        delay          = 0;
        cur_max_delay  = 1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        next_ready     = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_imem_req", imem_req, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_inst", inst_4W_out, 128'h0);
        checkOutput("rst_mask", inst_4W_valid_out, 4'h0);
        checkOutput("rst_pc", inst_4W_pc_out, 28'h0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        rst      = 1'b0;

        // Straight-line fetch from the reset PC.
        applyStimulus(10, 100, 100, 0, 1);
        checkOutput("boot_accepts", accepted_addr.size() >= 3, 1'b1);
        checkOutput("boot_out_count", out_log.size() >= 2, 1'b1);
        if (accepted_addr.size() >= 3 && out_log.size() >= 2) begin
            checkOutput("boot_addr0", accepted_addr[0], 32'h1C00_0000);
            checkOutput("boot_addr1", accepted_addr[1], 32'h1C00_0010);
            checkOutput("boot_addr2", accepted_addr[2], 32'h1C00_0020);
            checkOutput("boot_out0", out_log[0], {4'b1111, 28'h1C0_0000});
            checkOutput("boot_out1", out_log[1], {4'b1111, 28'h1C0_0001});
        end

        // Redirect into the middle of a block while idle in REQ.
        force_target = 32'h1C00_0108;
        force_mode   = 1;
        applyStimulus(12, 100, 100, 0, 1);
        checkOutput("redir_req_seen", (force_mode == 0) && accepted_addr.size() >= 1
                    && out_log.size() >= 2, 1'b1);
        if (accepted_addr.size() >= 1 && out_log.size() >= 2) begin
            checkOutput("redir_addr", accepted_addr[0], 32'h1C00_0100);
            checkOutput("redir_out0", out_log[0], {4'b0011, 28'h1C0_0010});
            checkOutput("redir_out1", out_log[1], {4'b1111, 28'h1C0_0011});
        end

        // Redirect while a response is outstanding; the late data is dropped.
        force_target = 32'h2000_0044;
        force_mode   = 2;
        applyStimulus(16, 100, 100, 0, 4);
        checkOutput("wait_redir_seen", (force_mode == 0) && accepted_addr.size() >= 1, 1'b1);
        if (accepted_addr.size() >= 1) begin
            checkOutput("wait_redir_addr", accepted_addr[0], 32'h2000_0040);
        end

        // Back-pressure fills the queue, then release drains it.
        applyStimulus(20, 100, 0, 0, 1);
        checkOutput("stall_full", out_valid, 1'b1);
        applyStimulus(16, 100, 100, 0, 1);

        // Long randomized run with redirects, stalls and variable latency.
        applyStimulus(3000, 70, 60, 5, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the 4-wide decode stage. It generates 16-byte-aligned fetch addresses, handles the request/response handshake with instruction memory, and applies redirects from the back end. Each returned block is queued with its per-slot valid mask and block PC. Its output drives the decode stage's `inst_4W_in`, `inst_4W_valid_in`, `inst_4W_pc_in` and `pre_valid` inputs, and it takes decode's `out_ready` as `next_ready`.

## Interface
Parameters:
- `RESET_PC`, default 32'h1C00_0000: first fetch address after reset. Bits [1:0] must be 0.
- `DEPTH`, default 4: queue entries. Must be a power of two, ≥2.

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: asynchronous, active-high reset.
- `redirect_valid` input 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc` input 32: new fetch PC. Bits [1:0] are ignored.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: block address, `{fetch_pc[31:4],4'b0}`.
- `imem_ack` input 1: the request is accepted when `imem_req && imem_ack`.
- `imem_rvalid` input 1: response valid. Responses are in order, at most one outstanding.
- `imem_rdata` input 128: slot 0 in [127:96], slot 3 in [31:0].
- `next_ready` input 1: downstream accepts the current output.
- `out_valid` output 1: an output block is available.
- `inst_4W_out` output 128: instruction block.
- `inst_4W_valid_out` output 4: bit 3 = slot 0, bit 0 = slot 3.
- `inst_4W_pc_out` output 28: block PC [31:4].

## Operation
- Registers:
  - `fetch_pc[31:2]`
  - `first`: the next block is the first block after reset or redirect.
  - FSM state.
  - Captured `req_pc[31:4]` and `req_mask[3:0]` for the outstanding request.
  - Queue with read/write pointers and count.
- Mask: if `first`, the mask is `4'b1111 >> fetch_pc[3:2]`; otherwise `4'b1111`.
- Space check: `space = (count + (state==WAIT)) < DEPTH`. The queue therefore never overflows.
- `imem_req = (state==REQ) && space && !redirect_valid`.
- FSM states:
  - REQ:
    - On `redirect_valid`: load `fetch_pc`, set `first`, stay in REQ.
    - Else on ack: capture `req_pc`/`req_mask`, set `fetch_pc = {fetch_pc[31:4]+1, 2'b00}`, clear `first`, go to WAIT.
  - WAIT:
    - On `redirect_valid`: load `fetch_pc`, set `first`. Go to REQ if `imem_rvalid` is asserted this cycle (the response is discarded), else go to DROP.
    - Else on `imem_rvalid`: push `{rdata, req_mask, req_pc}`, go to REQ.
  - DROP:
    - On `redirect_valid`: load `fetch_pc`, set `first`, stay in DROP.
    - On `imem_rvalid`: discard the response, go to REQ.
- Output:
  - `out_valid = (count != 0)`. The data fields are the head entry.
  - Pop when `out_valid && next_ready`.
  - Outputs are held stable while `out_valid && !next_ready`.
- Redirect:
  - The queue is cleared in the same edge: count=0, pointers=0.
  - Any pop or push in that cycle is void.
  - `out_valid` is 0 in the following cycle.
- Simultaneous push and pop: the count is unchanged, and both happen.
- PC wrap: `fetch_pc[31:4]` wraps from all-ones to 0 silently.

## Timing
- Values while `rst` is asserted:
  - state=REQ, `fetch_pc=RESET_PC[31:2]`, `first=1`, count=0.
  - `imem_req` is forced to 0 while `rst` is high.
  - `out_valid=0`; `inst_4W_out`, `inst_4W_valid_out` and `inst_4W_pc_out` are 0.
- `imem_req` may assert in the first cycle after `rst` deasserts.
- Latency: ack at cycle t, rvalid at t+k (k≥1). The block appears on the output at t+k+1 (registered queue).
- Back-to-back throughput: one block per 2 cycles at k=1, because a new request is issued the cycle after the response.
- Reset mid-operation: the asynchronous clear above applies. A response arriving after reset deasserts, but belonging to a pre-reset request, is the memory side's responsibility. The memory side must be reset by the same `rst`.

## Configuration
- `FETCH_QUEUE_BYPASS_EN`:
  - When defined: if count==0 and `imem_rvalid` is accepted in WAIT, the response drives the outputs combinationally in the same cycle, with `out_valid=1`. If `next_ready` is also high, the block is not pushed.
  - When undefined: every response goes through the queue (latency as in Timing).
  - Redirect overrides the bypass in both builds.

## Structure
- `defines.vh` holds:
  - FSM encodings `` `FQ_REQ ``, `` `FQ_WAIT ``, `` `FQ_DROP ``.
  - `` `FETCH_BLOCK_W `` (128).
  - `` `FETCH_PC_W `` (28).
- Sub-module `fetch_fifo`: parameterized DEPTH × (128+4+28) storage with push, pop, flush, count, and a head read. `fetch_queue` holds the PC, FSM and bypass.

## Test plan
- Reset release with `imem_ack=1`, rvalid one cycle after each ack, `next_ready=1`:
  - `imem_addr` sequence 0x1C000000, 0x1C000010, 0x1C000020.
  - Outputs have mask 4'b1111 and pc 0x1C00000, 0x1C00001.
- Redirect to 0x1C000108 while in REQ:
  - Next `imem_addr` is 0x1C000100.
  - First output mask is 4'b0011, pc 0x1C00010.
  - Next block mask is 4'b1111.
- Redirect while in WAIT, rvalid 3 cycles later with rdata 0xDEAD…:
  - The data never appears on the output.
  - The next request is issued at the redirect target.
- `next_ready=0` with DEPTH=4:
  - Exactly 4 blocks are accepted, then `imem_req` stays 0.
  - Outputs are stable.
  - Raising `next_ready` drains the blocks in order and fetching resumes.
- Redirect in the same cycle as a pop and a push: count becomes 0 and `out_valid=0` next cycle.
- With `FETCH_QUEUE_BYPASS_EN` defined, count=0 and rvalid: `out_valid=1` in the rvalid cycle, and the queue stays empty.
